// File: rtl/step_quad_encoder_model.sv
// step_quad_encoder_model
// Turns a step/direction/enable pulse stream into rate-limited quadrature
// A/B edges. Accepted steps queue in a signed pending counter that the
// emitter drains one transition at a time, no faster than one transition
// every MIN_GAP clocks. Tracks absolute emitted position and raises sticky
// flags for dropped steps (pending saturation) and for steps that arrive too
// soon after a direction change.

module step_quad_encoder_model #(
    parameter int SYNC_STAGES = 2,   // synchronizer depth, >= 2
    parameter int POS_WIDTH   = 32,  // signed position width
    parameter int PEND_WIDTH  = 8,   // signed pending-step width
    parameter int MIN_GAP     = 4,   // min clocks between transitions, >= 1
    parameter int DIR_SETUP   = 2    // min stable synced DIR cycles before a step
) (
    input  logic                  CLK,
    input  logic                  resetn,
    input  logic                  STEP_IN,
    input  logic                  DIR_IN,
    input  logic                  EN_IN,
    input  logic                  err_clr,
    output logic                  ENC_A,
    output logic                  ENC_B,
    output logic [POS_WIDTH-1:0]  position,
    output logic [PEND_WIDTH-1:0] pending,
    output logic                  busy,
    output logic                  overflow_err,
    output logic                  dir_setup_err
);

    // Gap timer only needs to hold MIN_GAP-1.
    localparam int GAP_W  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    // Direction-stable counter saturates at DIR_SETUP.
    localparam int DCNT_W = $clog2(DIR_SETUP + 2);
    // Two guard bits so pending +/- 1 +/- 1 never wraps before the range test.
    localparam int SUM_W  = PEND_WIDTH + 2;

    localparam logic signed [SUM_W-1:0]  PEND_MAX   = SUM_W'((2 ** (PEND_WIDTH - 1)) - 1);
    localparam logic signed [SUM_W-1:0]  PEND_MIN   = -PEND_MAX;
    localparam logic        [GAP_W-1:0]  GAP_RELOAD = GAP_W'(MIN_GAP - 1);
    localparam logic        [DCNT_W-1:0] DIR_SAT    = DCNT_W'(DIR_SETUP);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } emit_state_t;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] step_sync;
    logic [SYNC_STAGES-1:0] dir_sync;
    logic [SYNC_STAGES-1:0] en_sync;
    logic                   step_prev;
    logic                   dir_prev;

    logic step_s;
    logic dir_s;
    logic en_s;

    assign step_s = step_sync[SYNC_STAGES-1];
    assign dir_s  = dir_sync[SYNC_STAGES-1];
    assign en_s   = en_sync[SYNC_STAGES-1];

    // Shift the asynchronous inputs through the synchronizer chains and keep
    // the last synced STEP/DIR for edge and change detection.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            step_sync <= '0;
            dir_sync  <= '0;
            en_sync   <= '0;
            step_prev <= 1'b0;
            dir_prev  <= 1'b0;
        end else begin
            step_sync <= {step_sync[SYNC_STAGES-2:0], STEP_IN};
            dir_sync  <= {dir_sync[SYNC_STAGES-2:0], DIR_IN};
            en_sync   <= {en_sync[SYNC_STAGES-2:0], EN_IN};
            step_prev <= step_s;
            dir_prev  <= dir_s;
        end
    end

    // ------------------------------------------------------------------
    // Step acceptance and direction-setup tracking
    // ------------------------------------------------------------------
    logic              step_evt;
    logic              accept;
    logic [DCNT_W-1:0] dir_cnt;
    logic [DCNT_W-1:0] dir_cnt_eff;
    logic [DCNT_W-1:0] dir_cnt_next;
    logic              setup_viol;

    // The cycle in which synced DIR changes counts as zero stable cycles;
    // each following cycle adds one, saturating at DIR_SETUP.
    // NOTE: every combinational output is assigned on every path so no
    // latch can be inferred.
    always_comb begin
        step_evt     = step_s & ~step_prev;
        accept       = step_evt & en_s;
        dir_cnt_eff  = (dir_s != dir_prev) ? '0 : dir_cnt;
        dir_cnt_next = (dir_cnt_eff >= DIR_SAT) ? DIR_SAT : dir_cnt_eff + 1'b1;
        setup_viol   = accept & (dir_cnt_eff < DIR_SAT);
    end

    // Register the stable-direction count; reset as if DIR has long been stable.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            dir_cnt <= DIR_SAT;
        end else begin
            dir_cnt <= dir_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Emitter decision and pending arithmetic
    // ------------------------------------------------------------------
    emit_state_t            state;
    logic [GAP_W-1:0]       gap;
    logic [1:0]             phase;

    logic                   emit;
    logic                   emit_fwd;
    logic signed [SUM_W-1:0] delta_in;
    logic signed [SUM_W-1:0] delta_out;
    logic signed [SUM_W-1:0] pend_sum;
    logic                   sum_ok;
    logic                   overflow_set;
    logic [PEND_WIDTH-1:0]  pending_next;
    logic [1:0]             phase_next;
    logic                   gap_busy_next;

    // Decide whether a transition leaves this cycle, net the accepted and
    // emitted steps into pending, and drop the accepted step if the result
    // would leave the symmetric signed range.
    always_comb begin
        emit     = (state == ST_IDLE) && (gap == '0) && (pending != '0);
        emit_fwd = ~pending[PEND_WIDTH-1];

        delta_in = '0;
        if (accept) begin
            delta_in = dir_s ? SUM_W'(1) : SUM_W'(-1);
        end

        delta_out = '0;
        if (emit) begin
            delta_out = emit_fwd ? SUM_W'(1) : SUM_W'(-1);
        end

        pend_sum     = $signed({{2{pending[PEND_WIDTH-1]}}, pending}) + delta_in - delta_out;
        sum_ok       = (pend_sum <= PEND_MAX) && (pend_sum >= PEND_MIN);
        overflow_set = accept & ~sum_ok;

        // Draining always moves toward zero, so only delta_in can overflow.
        if (sum_ok) begin
            pending_next = pend_sum[PEND_WIDTH-1:0];
        end else if (!emit) begin
            pending_next = pending;
        end else if (emit_fwd) begin
            pending_next = pending - 1'b1;
        end else begin
            pending_next = pending + 1'b1;
        end

        phase_next = phase;
        if (emit) begin
            phase_next = emit_fwd ? phase + 2'd1 : phase - 2'd1;
        end

        // Gap timer is non-zero after this edge if we reload it, or if we are
        // waiting and it has more than one cycle left.
        gap_busy_next = emit ? (MIN_GAP > 1) : ((state == ST_WAIT) && (gap > GAP_W'(1)));
    end

    // ------------------------------------------------------------------
    // Emitter FSM with registered quadrature outputs and position
    // ------------------------------------------------------------------
    // Phase p maps to A = p[1]^p[0], B = p[1]: 0=00, 1=10, 2=11, 3=01 (A,B).
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            gap      <= '0;
            phase    <= 2'd0;
            ENC_A    <= 1'b0;
            ENC_B    <= 1'b0;
            position <= '0;
        end else begin
            if (emit) begin
                phase    <= phase_next;
                ENC_A    <= phase_next[1] ^ phase_next[0];
                ENC_B    <= phase_next[1];
                position <= emit_fwd ? position + 1'b1 : position - 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (emit) begin
                        gap <= GAP_RELOAD;
                        if (MIN_GAP > 1) begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Leaving on the edge that takes gap to zero lets the next
                    // transition land exactly MIN_GAP clocks after the last.
                    if (gap > GAP_W'(1)) begin
                        gap <= gap - 1'b1;
                    end else begin
                        gap   <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    gap   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Update the pending counter and the registered busy indication.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            pending <= '0;
            busy    <= 1'b0;
        end else begin
            pending <= pending_next;
            busy    <= (pending_next != '0) | gap_busy_next;
        end
    end

    // Sticky error flags; a new error in the same cycle as err_clr wins.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            overflow_err  <= 1'b0;
            dir_setup_err <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow_err <= 1'b1;
            end else if (err_clr) begin
                overflow_err <= 1'b0;
            end

            if (setup_viol) begin
                dir_setup_err <= 1'b1;
            end else if (err_clr) begin
                dir_setup_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_step_quad_encoder_model.sv
// tb_step_quad_encoder_model
// Directed bench for step_quad_encoder_model. Two instances share the input
// stream: dut_f uses the default parameters, dut_s uses PEND_WIDTH=4 and
// MIN_GAP=8 so that bursts queue up and saturate quickly.

module tb_step_quad_encoder_model;

    logic clk = 1'b0;
    logic resetn;
    logic step_in;
    logic dir_in;
    logic en_in;
    logic err_clr;

    logic        f_enc_a, f_enc_b, f_busy, f_ovf, f_dse;
    logic [31:0] f_position;
    logic [7:0]  f_pending;

    logic        s_enc_a, s_enc_b, s_busy, s_ovf, s_dse;
    logic [31:0] s_position;
    logic [3:0]  s_pending;

    int checks   = 0;
    int failures = 0;

    // Transition monitor counts for dut_s: all edges and reverse (B-leading) edges.
    int         s_edges = 0;
    int         s_rev   = 0;
    logic [1:0] s_prev_ph = 2'd0;

    // Scratch for the throughput test.
    int         tr_cyc [8];
    logic [1:0] tr_val [8];
    logic [1:0] exp_ab [8];
    int         n_tr;
    int         max_p;
    int         e0, r0;

    always #5 clk = ~clk;

    step_quad_encoder_model dut_f (
        .CLK          (clk),
        .resetn       (resetn),
        .STEP_IN      (step_in),
        .DIR_IN       (dir_in),
        .EN_IN        (en_in),
        .err_clr      (err_clr),
        .ENC_A        (f_enc_a),
        .ENC_B        (f_enc_b),
        .position     (f_position),
        .pending      (f_pending),
        .busy         (f_busy),
        .overflow_err (f_ovf),
        .dir_setup_err(f_dse)
    );

    step_quad_encoder_model #(
        .PEND_WIDTH(4),
        .MIN_GAP   (8)
    ) dut_s (
        .CLK          (clk),
        .resetn       (resetn),
        .STEP_IN      (step_in),
        .DIR_IN       (dir_in),
        .EN_IN        (en_in),
        .err_clr      (err_clr),
        .ENC_A        (s_enc_a),
        .ENC_B        (s_enc_b),
        .position     (s_position),
        .pending      (s_pending),
        .busy         (s_busy),
        .overflow_err (s_ovf),
        .dir_setup_err(s_dse)
    );

    function automatic logic [1:0] ph(input logic a, input logic b);
        return {b, a ^ b};
    endfunction

    // Count dut_s quadrature transitions seen outside reset.
    always @(negedge clk) begin
        if (resetn && (ph(s_enc_a, s_enc_b) != s_prev_ph)) begin
            s_edges++;
            if (ph(s_enc_a, s_enc_b) == s_prev_ph - 2'd1) s_rev++;
        end
        s_prev_ph <= ph(s_enc_a, s_enc_b);
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        step_in = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // One STEP pulse: high for one clock, low for one clock. Call just after a negedge.
    task automatic pulse(input logic d);
        dir_in  = d;
        step_in = 1'b1;
        @(negedge clk);
        step_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        exp_ab = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        resetn  = 1'b0;
        step_in = 1'b0;
        dir_in  = 1'b1;
        en_in   = 1'b1;
        err_clr = 1'b0;

        // ---- Reset state ----
        @(negedge clk);
        check("rst_enc", {f_enc_a, f_enc_b}, 2'b00);
        check("rst_pos", f_position, 32'd0);
        check("rst_pend", f_pending, 8'd0);
        check("rst_busy", f_busy, 1'b0);
        check("rst_errs", {f_ovf, f_dse}, 2'b00);

        // ---- 1: single step latency ----
        do_reset();
        step_in = 1'b1;                 // rises before edge k
        @(negedge clk); step_in = 1'b0; // after k
        @(negedge clk);                 // after k+1
        check("t1_pend_k1", f_pending, 8'd0);
        check("t1_enc_k1", {f_enc_a, f_enc_b}, 2'b00);
        @(negedge clk);                 // after k+2
        check("t1_pend_k2", f_pending, 8'd1);
        check("t1_enc_k2", {f_enc_a, f_enc_b}, 2'b00);
        check("t1_busy_k2", f_busy, 1'b1);
        @(negedge clk);                 // after k+3
        check("t1_enc_k3", {f_enc_a, f_enc_b}, 2'b10);
        check("t1_pos_k3", f_position, 32'd1);
        check("t1_pend_k3", f_pending, 8'd0);
        repeat (8) @(negedge clk);
        check("t1_busy_end", f_busy, 1'b0);

        // ---- 2: 8 forward steps, transitions 4 clocks apart ----
        do_reset();
        n_tr = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) pulse(1'b1);
            end
            begin
                logic [1:0] last;
                last = {f_enc_a, f_enc_b};
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if ({f_enc_a, f_enc_b} != last) begin
                        if (n_tr < 8) begin
                            tr_cyc[n_tr] = c;
                            tr_val[n_tr] = {f_enc_a, f_enc_b};
                        end
                        n_tr++;
                        last = {f_enc_a, f_enc_b};
                    end
                end
            end
        join
        check("t2_ntrans", 32'(n_tr), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < n_tr) begin
                check($sformatf("t2_ab%0d", i), tr_val[i], exp_ab[i]);
                if (i > 0) check($sformatf("t2_gap%0d", i), 32'(tr_cyc[i] - tr_cyc[i-1]), 32'd4);
            end
        end
        check("t2_pos", f_position, 32'd8);
        check("t2_pend", f_pending, 8'd0);
        check("t2_busy", f_busy, 1'b0);

        // ---- 3: 5 forward then 3 reverse (dut_s) ----
        do_reset();
        e0 = s_edges;
        r0 = s_rev;
        for (int i = 0; i < 8; i++) pulse(i < 5);
        repeat (40) @(negedge clk);
        check("t3_pos", s_position, 32'd2);
        check("t3_pend", s_pending, 4'd0);
        check("t3_edges", 32'(s_edges - e0), 32'd2);
        check("t3_rev", 32'(s_rev - r0), 32'd0);
        check("t3_enc", {s_enc_a, s_enc_b}, 2'b11);

        // ---- 4: saturation at +7 (dut_s) ----
        dir_in = 1'b1;
        do_reset();
        max_p = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) pulse(1'b1);
            end
            begin
                for (int c = 0; c < 110; c++) begin
                    @(negedge clk);
                    if (int'($signed(s_pending)) > max_p) max_p = int'($signed(s_pending));
                end
            end
        join
        check("t4_max_pend", 32'(max_p), 32'd7);
        check("t4_ovf", s_ovf, 1'b1);
        check("t4_pos", s_position, 32'd12);
        check("t4_pend", s_pending, 4'd0);
        check("t4_busy", s_busy, 1'b0);
        clear_errors();
        check("t4_ovf_clr", s_ovf, 1'b0);

        // ---- 5: direction setup (dut_f) ----
        do_reset();
        dir_in = 1'b0;
        @(negedge clk);
        step_in = 1'b1;
        @(negedge clk);
        step_in = 1'b0;
        repeat (12) @(negedge clk);
        check("t5_dse", f_dse, 1'b1);
        check("t5_ovf", f_ovf, 1'b0);
        check("t5_pos", f_position, 32'hFFFF_FFFF);
        check("t5_enc", {f_enc_a, f_enc_b}, 2'b01);
        clear_errors();
        check("t5_dse_clr", f_dse, 1'b0);
        en_in = 1'b0;
        repeat (4) @(negedge clk);
        dir_in = 1'b1;
        @(negedge clk);
        step_in = 1'b1;
        @(negedge clk);
        step_in = 1'b0;
        repeat (12) @(negedge clk);
        check("t5_en0_pos", f_position, 32'hFFFF_FFFF);
        check("t5_en0_dse", f_dse, 1'b0);
        en_in = 1'b1;
        repeat (8) @(negedge clk);
        pulse(1'b1);
        repeat (12) @(negedge clk);
        check("t5_stable_pos", f_position, 32'd0);
        check("t5_stable_dse", f_dse, 1'b0);
        check("t5_stable_enc", {f_enc_a, f_enc_b}, 2'b00);

        // ---- 6: reset mid-burst (dut_s) ----
        do_reset();
        for (int i = 0; i < 7; i++) pulse(1'b1);
        @(negedge clk);
        check("t6_pend_pre", s_pending, 4'd5);
        #1;
        resetn = 1'b0;
        #1;
        check("t6_rst_enc", {s_enc_a, s_enc_b}, 2'b00);
        check("t6_rst_pos", s_position, 32'd0);
        check("t6_rst_pend", s_pending, 4'd0);
        check("t6_rst_busy", s_busy, 1'b0);
        check("t6_rst_errs", {s_ovf, s_dse}, 2'b00);
        check("t6_rst_fpos", f_position, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        e0 = s_edges;
        repeat (30) @(negedge clk);
        check("t6_no_edges", 32'(s_edges - e0), 32'd0);
        check("t6_pos_after", s_position, 32'd0);
        check("t6_pend_after", s_pending, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
